uart_brg_frac: RTL and testbench
================================

# uart_brg_frac

Parametrised fractional baud-rate generator for the UART, successor to the fixed 8-bit, two-mode generator. It produces an oversample tick from `pclk` using an integer divisor plus a fractional accumulator, with selectable 16x/8x/4x oversampling. From that tick it derives independent TX bit-shift and RX mid-bit sample/shift strobes. The RX phase can be resynchronised on a detected start bit. It sits between the APB register file (divisor/mode fields) and the UART TX/RX shifters.

## Interface
- `DIV_W`, default 16: width of the integer divisor and prescale counter.
- `FRAC_W`, default 4: width of the fractional divisor and accumulator.

- `pclk`  in  1  system clock; all state on its rising edge.
- `prst_n`  in  1  asynchronous active-low reset.
- `brg_en`  in  1  generator enable. 0 holds all state cleared.
- `brg_div`  in  DIV_W  integer divisor D. Nominal tick period is D+1 cycles.
- `brg_frac`  in  FRAC_W  fractional divisor F. Adds F/2^FRAC_W cycles to the average tick period.
- `brg_osel`  in  2  oversample select: 00=16x, 01=8x, 10=4x, 11=16x (reserved).
- `rx_resync`  in  1  single-cycle pulse from RX start-bit detector; restarts RX bit phase.
- `brg_tick`  out  1  oversample tick, one cycle wide.
- `brg_tx_shift`  out  1  TX bit boundary strobe.
- `brg_rx_sample`  out  1  RX mid-bit sample strobe.
- `brg_rx_shift`  out  1  RX bit boundary strobe.

## Operation
- State registers:
  - `pre_cnt[DIV_W-1:0]`
  - `acc[FRAC_W-1:0]`
  - `ext` (1 bit, extend-next-period flag)
  - `tx_os[3:0]` and `rx_os[3:0]` (oversample phase counters)
- Reset value: all registers 0. All outputs 0 while `prst_n`=0.
- Oversample count N = 16, 8 or 4 per `brg_osel`.
- Limit L = `brg_div` + `ext`, computed at DIV_W+1 bits so no overflow at D = all-ones.
- Tick:
  - `brg_tick` = `brg_en` & (`pre_cnt` >= L).
  - The >= comparison is required: if the divisor is lowered below the current count, the next cycle ticks instead of wrapping.
- Prescaler:
  - On a tick: `pre_cnt`<=0. {carry, `acc`} <= `acc` + `brg_frac` at FRAC_W+1 bits. `ext`<=carry.
  - Otherwise: `pre_cnt`<=`pre_cnt`+1.
- TX phase:
  - On a tick, `tx_os` <= (`tx_os` >= N-1) ? 0 : `tx_os`+1.
  - `brg_tx_shift` = `brg_tick` & (`tx_os` >= N-1).
- RX phase:
  - Same update rule as TX, applied to `rx_os`.
  - `brg_rx_sample` = `brg_tick` & (`rx_os` == N/2-1).
  - `brg_rx_shift` = `brg_tick` & (`rx_os` >= N-1).
- Resync:
  - `rx_resync`=1 forces `rx_os`<=0 that cycle, with priority over a coincident tick increment.
  - Strobes in that same cycle still decode from the pre-resync `rx_os`.
  - Prescaler, `acc`, `ext` and `tx_os` are unaffected.
- `brg_osel` change mid-bit: the >= compare makes a phase counter above the new N-1 wrap at the next tick, emitting a shift strobe.
- `brg_en`=0:
  - Synchronously clears all registers the next edge.
  - Outputs are combinationally forced to 0 in the same cycle.
- D=0, F=0: tick every cycle.
- Output decode is combinational from registered state plus `brg_en`, with no added latency. Consumers register the strobes.

## Timing
- First tick after `brg_en` rises (D, F stable, state cleared) is asserted in cycle D (0-based from the first enabled cycle).
- Steady tick period is D+1 cycles, or D+2 cycles for the period after an accumulator carry. Average period is D+1+F/2^FRAC_W.
- `brg_tx_shift` and `brg_rx_shift` occur every N ticks.
- `brg_rx_sample` leads `brg_rx_shift` by N/2 ticks.
- After `rx_resync` in cycle t, the first `brg_rx_sample` is the (N/2)-th tick after t, counting ticks strictly after t.
- Divisor and fraction inputs are sampled live every cycle; no shadow registers.
- Asynchronous reset mid-operation clears everything immediately. Output strobes drop in the same cycle.

## Test plan
- D=3, F=0, osel=00, en=1 from reset release:
  - `brg_tick` in cycles 3, 7, 11…
  - `brg_tx_shift` and `brg_rx_shift` first in cycle 63, then every 64 cycles.
  - `brg_rx_sample` first in cycle 31.
- FRAC_W=4, D=3, F=8:
  - Tick periods alternate 4, 5, 4, 5.
  - Average period 4.5 cycles; 32 ticks span exactly 144 cycles.
- osel=01 and 10 with D=0, F=0:
  - Tick every cycle.
  - Shift every 8 and 4 cycles respectively; sample at phase 3 and 1 respectively.
- D=9 steady state; at `pre_cnt`=7 change D to 2:
  - Tick in the next cycle.
  - Then period 3. No 2^DIV_W wrap.
- `rx_resync` pulsed at `rx_osphase` 10, coincident with a tick, 16x:
  - `rx_os`=0 next.
  - `brg_rx_sample` on the 8th following tick.
  - `tx_os` phase unchanged.
- Control interruptions mid-bit:
  - `brg_en` deasserted mid-bit: outputs 0 immediately, all counters 0 next edge. On re-enable, first tick at cycle D.
  - `prst_n` pulsed low mid-bit: same clear, asynchronously.

Source files
------------

// File: rtl/uart_brg_frac_if.sv
// Control and strobe bundle for the fractional baud-rate generator.
//
// master : register file / UART side. Drives enable, divisor, fraction,
//          oversample select and the RX resync pulse; receives the strobes.
// slave  : the generator itself.
//
// Signals:
//   brg_en        generator enable; 0 holds all state cleared
//   brg_div       integer divisor D (nominal tick period D+1 cycles)
//   brg_frac      fractional divisor F (adds F/2^FRAC_W cycles on average)
//   brg_osel      oversample select: 00=16x, 01=8x, 10=4x, 11=16x
//   rx_resync     single-cycle pulse from the RX start-bit detector
//   brg_tick      oversample tick, one cycle wide
//   brg_tx_shift  TX bit boundary strobe
//   brg_rx_sample RX mid-bit sample strobe
//   brg_rx_shift  RX bit boundary strobe
interface uart_brg_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              brg_en;
    logic [DIV_W-1:0]  brg_div;
    logic [FRAC_W-1:0] brg_frac;
    logic [1:0]        brg_osel;
    logic              rx_resync;
    logic              brg_tick;
    logic              brg_tx_shift;
    logic              brg_rx_sample;
    logic              brg_rx_shift;

    modport master (
        output brg_en, brg_div, brg_frac, brg_osel, rx_resync,
        input  brg_tick, brg_tx_shift, brg_rx_sample, brg_rx_shift
    );

    modport slave (
        input  brg_en, brg_div, brg_frac, brg_osel, rx_resync,
        output brg_tick, brg_tx_shift, brg_rx_sample, brg_rx_shift
    );
endinterface

// File: rtl/uart_brg_frac.sv
// Fractional baud-rate generator for the UART.
//
// A prescaler counts pclk cycles up to D (+1 when the fractional accumulator
// carried on the previous tick) and emits an oversample tick. Two independent
// phase counters divide the tick by N (16/8/4) to give the TX bit boundary,
// the RX mid-bit sample and the RX bit boundary strobes. The RX phase can be
// restarted by a start-bit detector.
//
// Ports:
//   pclk    system clock, all state on its rising edge
//   prst_n  asynchronous active-low reset; also forces the outputs low
//   bus     uart_brg_frac_if.slave: enable/divisor/fraction/osel/resync in,
//           tick and strobes out
module uart_brg_frac #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic            pclk,
    input  logic            prst_n,
    uart_brg_frac_if.slave  bus
);

    logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [3:0]        tx_os_q, tx_os_d;
    logic [3:0]        rx_os_q, rx_os_d;

    logic              active;
    logic [DIV_W:0]    limit;
    logic [FRAC_W:0]   acc_sum;
    logic              tick;
    logic [3:0]        os_last;
    logic [3:0]        os_mid;

    // Outputs must drop the moment reset asserts, even with D=0 where the
    // cleared prescaler alone would satisfy the tick compare.
    assign active  = bus.brg_en & prst_n;

    // One bit wider than the divisor so D=all-ones plus the extend flag
    // cannot wrap.
    assign limit   = {1'b0, bus.brg_div} + {{DIV_W{1'b0}}, ext_q};
    assign acc_sum = {1'b0, acc_q} + {1'b0, bus.brg_frac};

    // >= rather than == so a divisor lowered below the running count ticks
    // at once instead of wrapping through 2^DIV_W.
    assign tick    = active & ({1'b0, pre_cnt_q} >= limit);

    always_comb begin
        case (bus.brg_osel)
            2'b01:   begin os_last = 4'd7;  os_mid = 4'd3; end
            2'b10:   begin os_last = 4'd3;  os_mid = 4'd1; end
            default: begin os_last = 4'd15; os_mid = 4'd7; end
        endcase
    end

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        acc_d     = acc_q;
        ext_d     = ext_q;
        tx_os_d   = tx_os_q;
        rx_os_d   = rx_os_q;
        if (!bus.brg_en) begin
            pre_cnt_d = '0;
            acc_d     = '0;
            ext_d     = 1'b0;
            tx_os_d   = '0;
            rx_os_d   = '0;
        end else begin
            if (tick) begin
                pre_cnt_d = '0;
                acc_d     = acc_sum[FRAC_W-1:0];
                ext_d     = acc_sum[FRAC_W];
                // >= so a phase left above a newly reduced N wraps next tick.
                tx_os_d   = (tx_os_q >= os_last) ? 4'd0 : tx_os_q + 4'd1;
                rx_os_d   = (rx_os_q >= os_last) ? 4'd0 : rx_os_q + 4'd1;
            end else begin
                pre_cnt_d = pre_cnt_q + DIV_W'(1);
            end
            // Start-bit resync wins over a coincident tick increment.
            if (bus.rx_resync) begin
                rx_os_d = '0;
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pre_cnt_q <= '0;
            acc_q     <= '0;
            ext_q     <= 1'b0;
            tx_os_q   <= '0;
            rx_os_q   <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            acc_q     <= acc_d;
            ext_q     <= ext_d;
            tx_os_q   <= tx_os_d;
            rx_os_q   <= rx_os_d;
        end
    end

    // Strobes decode from the current (pre-resync) phase.
    assign bus.brg_tick      = tick;
    assign bus.brg_tx_shift  = tick & (tx_os_q >= os_last);
    assign bus.brg_rx_sample = tick & (rx_os_q == os_mid);
    assign bus.brg_rx_shift  = tick & (rx_os_q >= os_last);

endmodule

// File: tb/tb_uart_brg_frac.sv
// Directed bench for uart_brg_frac. Each scenario logs the four outputs per
// cycle, then compares event positions against hand-computed cycle numbers.
module tb_uart_brg_frac;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int          LOG_N  = 1024;

    logic pclk   = 1'b0;
    logic prst_n = 1'b0;

    uart_brg_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_brg_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .pclk   (pclk),
        .prst_n (prst_n),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle output log; index = cycle since last clear_log.
    logic lg_tick [LOG_N];
    logic lg_txs  [LOG_N];
    logic lg_rxsa [LOG_N];
    logic lg_rxsh [LOG_N];
    int   pos = 0;

    task automatic clear_log();
        pos = 0;
    endtask

    // Inputs are changed at posedge+1; outputs sampled at the following negedge.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            if (pos < LOG_N) begin
                lg_tick[pos] = bus.brg_tick;
                lg_txs[pos]  = bus.brg_tx_shift;
                lg_rxsa[pos] = bus.brg_rx_sample;
                lg_rxsh[pos] = bus.brg_rx_shift;
            end
            pos++;
            @(posedge pclk);
            #1;
        end
    endtask

    function automatic logic ev(input int sel, input int idx);
        case (sel)
            0:       return lg_tick[idx];
            1:       return lg_txs[idx];
            2:       return lg_rxsa[idx];
            default: return lg_rxsh[idx];
        endcase
    endfunction

    // Cycle index of the n-th (0-based) event of kind sel at or after 'from'.
    function automatic int nth(input int sel, input int n, input int from);
        int seen = 0;
        for (int i = from; i < pos && i < LOG_N; i++) begin
            if (ev(sel, i)) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int count(input int sel, input int from, input int to);
        int c = 0;
        for (int i = from; i < to && i < pos && i < LOG_N; i++) begin
            if (ev(sel, i)) c++;
        end
        return c;
    endfunction

    task automatic disable_one_cycle();
        bus.brg_en = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        bus.brg_en    = 1'b1;
        bus.brg_div   = '0;
        bus.brg_frac  = '0;
        bus.brg_osel  = 2'b00;
        bus.rx_resync = 1'b0;

        // Reset held with en=1, D=0: outputs still forced low.
        #12;
        check("rst_tick",      int'(bus.brg_tick),      0);
        check("rst_tx_shift",  int'(bus.brg_tx_shift),  0);
        check("rst_rx_sample", int'(bus.brg_rx_sample), 0);

        // D=3, F=0, 16x from reset release.
        @(posedge pclk);
        #1;
        bus.brg_div = 16'd3;
        prst_n      = 1'b1;
        clear_log();
        observe(140);
        check("t1_first_tick",  nth(0, 0, 0), 3);
        check("t1_tick_count",  count(0, 0, 140), 35);
        check("t1_tx_shift0",   nth(1, 0, 0), 63);
        check("t1_tx_shift1",   nth(1, 1, 0), 127);
        check("t1_rx_shift0",   nth(3, 0, 0), 63);
        check("t1_rx_sample0",  nth(2, 0, 0), 31);
        check("t1_rx_sample1",  nth(2, 1, 0), 95);

        // F=8: periods alternate 4,5; 32 ticks span 144 cycles.
        disable_one_cycle();
        bus.brg_frac = 4'd8;
        bus.brg_en   = 1'b1;
        clear_log();
        observe(150);
        check("t2_first_tick", nth(0, 0, 0), 3);
        check("t2_period1",    nth(0, 1, 0) - nth(0, 0, 0), 4);
        check("t2_period2",    nth(0, 2, 0) - nth(0, 1, 0), 5);
        check("t2_period3",    nth(0, 3, 0) - nth(0, 2, 0), 4);
        check("t2_period4",    nth(0, 4, 0) - nth(0, 3, 0), 5);
        check("t2_span32",     nth(0, 32, 0) - nth(0, 0, 0), 144);

        // D=0 with en=1 ticks; dropping en kills outputs in the same cycle.
        bus.brg_div  = '0;
        bus.brg_frac = '0;
        #1;
        check("t3_tick_live", int'(bus.brg_tick), 1);
        bus.brg_en = 1'b0;
        #1;
        check("t3_en_off_tick",  int'(bus.brg_tick),     0);
        check("t3_en_off_shift", int'(bus.brg_rx_shift), 0);
        @(posedge pclk);
        #1;
        bus.brg_osel = 2'b01;
        bus.brg_en   = 1'b1;
        clear_log();
        observe(32);
        check("t3_8x_ticks",     count(0, 0, 32), 32);
        check("t3_8x_tx_shift0", nth(1, 0, 0), 7);
        check("t3_8x_tx_shift1", nth(1, 1, 0), 15);
        check("t3_8x_rx_shift0", nth(3, 0, 0), 7);
        check("t3_8x_sample0",   nth(2, 0, 0), 3);

        disable_one_cycle();
        bus.brg_osel = 2'b10;
        bus.brg_en   = 1'b1;
        clear_log();
        observe(16);
        check("t3_4x_tx_shift0", nth(1, 0, 0), 3);
        check("t3_4x_tx_shift1", nth(1, 1, 0), 7);
        check("t3_4x_sample0",   nth(2, 0, 0), 1);
        check("t3_4x_sample1",   nth(2, 1, 0), 5);

        // D=9; when pre_cnt reaches 7 (cycle 27), drop D to 2.
        disable_one_cycle();
        bus.brg_div  = 16'd9;
        bus.brg_osel = 2'b00;
        bus.brg_en   = 1'b1;
        clear_log();
        observe(28);
        check("t4_ticks_before", count(0, 0, 28), 2);
        check("t4_tick1",        nth(0, 1, 0), 19);
        bus.brg_div = 16'd2;
        observe(10);
        check("t4_tick_after0", nth(0, 0, 28), 28);
        check("t4_tick_after1", nth(0, 1, 28), 31);
        check("t4_tick_after2", nth(0, 2, 28), 34);

        // D=1: tick k at cycle 2k+1. Resync at tick 10 (cycle 21, rx_os=10).
        disable_one_cycle();
        bus.brg_div = 16'd1;
        bus.brg_en  = 1'b1;
        clear_log();
        observe(21);
        bus.rx_resync = 1'b1;
        observe(1);
        bus.rx_resync = 1'b0;
        observe(50);
        check("t5_resync_on_tick", nth(0, 10, 0), 21);
        check("t5_sample_before",  nth(2, 0, 0), 15);
        check("t5_tick_after",     nth(0, 0, 22), 23);
        check("t5_sample_after",   nth(2, 0, 22), 37);
        check("t5_rx_shift",       nth(3, 0, 0), 53);
        check("t5_tx_shift0",      nth(1, 0, 0), 31);
        check("t5_tx_shift1",      nth(1, 1, 0), 63);

        // Async reset mid-cycle with D=0: tick must drop before any edge.
        bus.brg_div = '0;
        @(negedge pclk);
        #2;
        check("t6_tick_pre_rst", int'(bus.brg_tick), 1);
        prst_n = 1'b0;
        #1;
        check("t6_rst_tick",  int'(bus.brg_tick),     0);
        check("t6_rst_shift", int'(bus.brg_tx_shift), 0);
        @(posedge pclk);
        #1;
        bus.brg_div = 16'd3;
        prst_n      = 1'b1;
        clear_log();
        observe(70);
        check("t6_first_tick", nth(0, 0, 0), 3);
        check("t6_tx_shift0",  nth(1, 0, 0), 63);
        check("t6_rx_sample0", nth(2, 0, 0), 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
